// File: rtl/hex_scan_pkg.sv
// Shared types and helpers for the multiplexed hex display scanner.
package hex_scan_pkg;

    localparam int unsigned NIBBLE_W = 4;

    // GUARD is the dark anti-ghosting cycle at the start of every slot.
    typedef enum logic {
        SlotGuard,
        SlotDrive
    } slot_state_e;

    // Width of a counter that must hold 0..n-1; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hex_digit_scanner_if.sv
// Load handshake plus decoder-facing display outputs of the hex scanner.
interface hex_digit_scanner_if #(
    parameter int unsigned NUM_DIGITS = 4
);
    logic                                         load_valid;
    logic                                         load_ready;
    logic [hex_scan_pkg::NIBBLE_W*NUM_DIGITS-1:0] load_data;
    logic [hex_scan_pkg::NIBBLE_W-1:0]            nibble;
    logic [NUM_DIGITS-1:0]                        digit_en_n;
    logic                                         blank;
    logic                                         frame_done;

    // Producer / display-consumer side.
    modport master (
        output load_valid,
        output load_data,
        input  load_ready,
        input  nibble,
        input  digit_en_n,
        input  blank,
        input  frame_done
    );

    // Scanner side.
    modport slave (
        input  load_valid,
        input  load_data,
        output load_ready,
        output nibble,
        output digit_en_n,
        output blank,
        output frame_done
    );
endinterface

// File: rtl/scan_slot_timer.sv
// Slot sequencer: per-slot counter, digit index and GUARD/DRIVE state.
module scan_slot_timer
    import hex_scan_pkg::*;
#(
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned REFRESH_DIV = 1024,
    parameter int unsigned IdxW        = idx_width(NUM_DIGITS),
    parameter int unsigned CntW        = idx_width(REFRESH_DIV)
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [IdxW-1:0] idx_o,
    output slot_state_e     state_o,
    output logic            frame_done_o
);
    localparam logic [CntW-1:0] CntLast = CntW'(REFRESH_DIV - 1);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(NUM_DIGITS - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic [IdxW-1:0] idx_q, idx_d;
    slot_state_e     state_q, state_d;

    // Next-state: GUARD lasts one cycle, DRIVE runs to the end of the slot.
    always_comb begin
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        state_d = state_q;
        unique case (state_q)
            SlotGuard: state_d = SlotDrive;
            SlotDrive: begin
                if (cnt_q == CntLast) begin
                    state_d = SlotGuard;
                    cnt_d   = '0;
                    idx_d   = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
                end
            end
            default: state_d = SlotGuard;
        endcase
    end

    // State register; reset restarts the scan at digit 0 GUARD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            state_q <= SlotGuard;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            state_q <= state_d;
        end
    end

    // Last cycle of the frame; REFRESH_DIV>=2 means it is always a DRIVE cycle.
    always_comb begin
        idx_o        = idx_q;
        state_o      = state_q;
        frame_done_o = (state_q == SlotDrive) && (cnt_q == CntLast) && (idx_q == IdxLast);
    end

endmodule

// File: rtl/hex_digit_scanner.sv
// Multiplexed hex display driver: load handshake, frame-aligned commit,
// leading-zero blanking and active-low digit enable decode.
module hex_digit_scanner
    import hex_scan_pkg::*;
#(
    parameter int unsigned NUM_DIGITS    = 4,
    parameter int unsigned REFRESH_DIV   = 1024,
    parameter int unsigned BLANK_LEADING = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    hex_digit_scanner_if.slave  bus
);
    localparam int unsigned IdxW  = idx_width(NUM_DIGITS);
    localparam int unsigned CntW  = idx_width(REFRESH_DIV);
    localparam int unsigned DataW = NIBBLE_W * NUM_DIGITS;

    logic [DataW-1:0]      display_q, display_d;
    logic [DataW-1:0]      pending_q, pending_d;
    logic                  pending_valid_q, pending_valid_d;
    logic [IdxW-1:0]       idx;
    slot_state_e           state;
    logic                  frame_done;
    logic [NUM_DIGITS-1:0] suppress;
    logic                  zero_run;
    logic                  drive;

    scan_slot_timer #(
        .NUM_DIGITS  (NUM_DIGITS),
        .REFRESH_DIV (REFRESH_DIV),
        .IdxW        (IdxW),
        .CntW        (CntW)
    ) u_timer (
        .clk          (clk),
        .rst_n        (rst_n),
        .idx_o        (idx),
        .state_o      (state),
        .frame_done_o (frame_done)
    );

    // Handshake into pending; pending moves to display only at a frame boundary.
    // A load on the boundary cycle needs pending empty, so it waits a full frame.
    always_comb begin
        display_d       = display_q;
        pending_d       = pending_q;
        pending_valid_d = pending_valid_q;
        if (frame_done && pending_valid_q) begin
            display_d       = pending_q;
            pending_valid_d = 1'b0;
        end
        if (bus.load_valid && !pending_valid_q) begin
            pending_d       = bus.load_data;
            pending_valid_d = 1'b1;
        end
    end

    // Pending and display registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            display_q       <= '0;
            pending_q       <= '0;
            pending_valid_q <= 1'b0;
        end else begin
            display_q       <= display_d;
            pending_q       <= pending_d;
            pending_valid_q <= pending_valid_d;
        end
    end

    // Digit i>0 is dark when it and every higher digit are zero.
    always_comb begin
        suppress = '0;
        zero_run = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_run    = zero_run && (display_q[i*NIBBLE_W +: NIBBLE_W] == '0);
            suppress[i] = (BLANK_LEADING != 0) && zero_run;
        end
    end

    // Output decode from registered state only.
    always_comb begin
        drive          = (state == SlotDrive) && !suppress[idx];
        bus.nibble     = display_q[int'(idx)*NIBBLE_W +: NIBBLE_W];
        bus.digit_en_n = '1;
        if (drive) begin
            bus.digit_en_n[idx] = 1'b0;
        end
        bus.blank      = !drive;
        bus.frame_done = frame_done;
        bus.load_ready = !pending_valid_q;
    end

endmodule

// File: tb/tb_hex_digit_scanner.sv
// Directed bench: NUM_DIGITS=4, REFRESH_DIV=4, blanking on (u_dut_a) and off (u_dut_b).
module tb_hex_digit_scanner;
    logic clk;
    logic rst_n;
    int   cyc;
    int   n_chk;
    int   n_pass;

    hex_digit_scanner_if #(.NUM_DIGITS(4)) ifa ();
    hex_digit_scanner_if #(.NUM_DIGITS(4)) ifb ();

    hex_digit_scanner #(
        .NUM_DIGITS    (4),
        .REFRESH_DIV   (4),
        .BLANK_LEADING (1)
    ) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa.slave)
    );

    hex_digit_scanner #(
        .NUM_DIGITS    (4),
        .REFRESH_DIV   (4),
        .BLANK_LEADING (0)
    ) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    task automatic chk_a(input string tag, input logic [3:0] en, input logic [3:0] nib,
                         input logic blk);
        chk({tag, "_en"},    ifa.digit_en_n, en);
        chk({tag, "_nib"},   ifa.nibble,     nib);
        chk({tag, "_blank"}, ifa.blank,      blk);
    endtask

    task automatic drive(input logic v, input logic [15:0] d);
        ifa.load_valid = v;
        ifa.load_data  = d;
        ifb.load_valid = v;
        ifb.load_data  = d;
    endtask

    // Cycle c is the interval ending at the (c+1)-th rising edge after release.
    task automatic step_to(input int c);
        while (cyc < c) begin
            @(negedge clk);
            cyc++;
        end
        #1;
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        cyc    = 0;
        rst_n  = 1'b0;
        drive(1'b0, 16'h0000);
        repeat (2) @(negedge clk);
        #1;
        chk_a("rst", 4'hF, 4'h0, 1'b1);
        chk("rst_ready", ifa.load_ready, 1);
        chk("rst_fd", ifa.frame_done, 0);

        rst_n = 1'b1;
        cyc   = 0;
        chk_a("c0_guard", 4'hF, 4'h0, 1'b1);
        step_to(1);
        chk_a("c1_zero", 4'hE, 4'h0, 1'b0);
        step_to(2);
        chk("c2_ready", ifa.load_ready, 1);
        drive(1'b1, 16'h1A2F);
        step_to(3);
        drive(1'b0, 16'h0000);
        chk("c3_ready", ifa.load_ready, 0);
        step_to(5);
        chk_a("c5_sup", 4'hF, 4'h0, 1'b1);
        step_to(14);
        chk("c14_fd", ifa.frame_done, 0);
        step_to(15);
        chk("c15_fd", ifa.frame_done, 1);
        step_to(16);
        chk("c16_ready", ifa.load_ready, 1);
        chk_a("c16_guard", 4'hF, 4'hF, 1'b1);
        step_to(17);
        chk_a("c17", 4'hE, 4'hF, 1'b0);
        step_to(20);
        chk_a("c20_guard", 4'hF, 4'h2, 1'b1);
        step_to(21);
        chk_a("c21", 4'hD, 4'h2, 1'b0);
        step_to(25);
        chk_a("c25", 4'hB, 4'hA, 1'b0);
        step_to(29);
        chk_a("c29", 4'h7, 4'h1, 1'b0);

        // Load on the boundary cycle, then hold a second value under backpressure.
        step_to(31);
        chk("c31_fd", ifa.frame_done, 1);
        chk("c31_ready", ifa.load_ready, 1);
        drive(1'b1, 16'h0005);
        step_to(32);
        chk("c32_ready", ifa.load_ready, 0);
        drive(1'b1, 16'h0000);
        step_to(33);
        chk_a("c33_old", 4'hE, 4'hF, 1'b0);
        step_to(40);
        chk("c40_ready", ifa.load_ready, 0);
        step_to(45);
        chk_a("c45_old", 4'h7, 4'h1, 1'b0);
        step_to(47);
        chk("c47_fd", ifa.frame_done, 1);
        chk("c47_ready", ifa.load_ready, 0);
        step_to(48);
        chk("c48_ready", ifa.load_ready, 1);
        step_to(49);
        chk("c49_ready", ifa.load_ready, 0);
        drive(1'b0, 16'h0000);
        chk_a("c49_five", 4'hE, 4'h5, 1'b0);
        chk("c49_b_en", ifb.digit_en_n, 4'hE);
        step_to(53);
        chk_a("c53_sup", 4'hF, 4'h0, 1'b1);
        chk("c53_b_en", ifb.digit_en_n, 4'hD);
        chk("c53_b_blank", ifb.blank, 0);
        step_to(57);
        chk("c57_b_en", ifb.digit_en_n, 4'hB);
        chk("c57_b_nib", ifb.nibble, 4'h0);
        step_to(61);
        chk("c61_a_en", ifa.digit_en_n, 4'hF);
        step_to(65);
        chk_a("c65_zero", 4'hE, 4'h0, 1'b0);
        step_to(66);
        chk("c66_ready", ifa.load_ready, 1);
        drive(1'b1, 16'h1234);
        step_to(67);
        drive(1'b0, 16'h0000);
        chk("c67_ready", ifa.load_ready, 0);
        step_to(69);
        chk_a("c69_sup", 4'hF, 4'h0, 1'b1);
        step_to(81);
        chk_a("c81", 4'hE, 4'h4, 1'b0);
        step_to(90);
        chk_a("c90", 4'hB, 4'h2, 1'b0);

        // Asynchronous reset in the middle of slot 2 DRIVE.
        #1 rst_n = 1'b0;
        #1;
        chk_a("mid_rst", 4'hF, 4'h0, 1'b1);
        chk("mid_rst_ready", ifa.load_ready, 1);
        chk("mid_rst_fd", ifa.frame_done, 0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        cyc   = 0;
        chk_a("r0_guard", 4'hF, 4'h0, 1'b1);
        step_to(1);
        chk_a("r1", 4'hE, 4'h0, 1'b0);
        step_to(5);
        chk_a("r5_sup", 4'hF, 4'h0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
